adder_carry_select_pipe: RTL

ADDER_CARRY_SELECT_PIPE -- requirements
Module: adder_carry_select_pipe

---
 rtl/adder_carry_select_pipe_pkg.sv | 9 +
 rtl/adder_chunk_select.sv | 22 ++
 rtl/adder_carry_select_pipe.sv | 120 ++++++++++++
 3 files changed

// File: rtl/adder_carry_select_pipe_pkg.sv
// Shared types and default sizing for the multi-cycle carry-select adder.
package adder_carry_select_pipe_pkg;

    localparam int unsigned DefaultNbits = 32;
    localparam int unsigned DefaultChunk = 8;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

endpackage

// File: rtl/adder_chunk_select.sv
// One carry-select slice: both carry-in candidates are formed in parallel and
// the registered carry picks one.
module adder_chunk_select #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_sel_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o
);

    logic [CHUNK:0] cand0;
    logic [CHUNK:0] cand1;

    assign cand0 = {1'b0, a_i} + {1'b0, b_i};
    assign cand1 = {1'b0, a_i} + {1'b0, b_i} + (CHUNK + 1)'(1);

    assign sum_o  = cin_sel_i ? cand1[CHUNK-1:0] : cand0[CHUNK-1:0];
    assign cout_o = cin_sel_i ? cand1[CHUNK]     : cand0[CHUNK];

endmodule

// File: rtl/adder_carry_select_pipe.sv
// Add/subtract resolved one CHUNK-wide slice per cycle, with a valid/ready
// request side and a result held in DONE until the consumer takes it.
module adder_carry_select_pipe
    import adder_carry_select_pipe_pkg::*;
#(
    parameter int unsigned NBITS = DefaultNbits,
    parameter int unsigned CHUNK = DefaultChunk
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    input  logic             cin,
    input  logic             sub,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [NBITS-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned N  = NBITS / CHUNK;
    localparam int unsigned KW = $clog2(N);
    localparam int unsigned IW = $clog2(NBITS);

    state_e            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [NBITS-1:0]  a_q, a_d;
    logic [NBITS-1:0]  b_q, b_d;
    logic [NBITS-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              ovf_q, ovf_d;

    logic [IW-1:0]     base;
    logic [CHUNK-1:0]  chunk_sum;
    logic              chunk_carry;
    logic              last;

    assign base = IW'(k_q) * IW'(CHUNK);
    assign last = (k_q == KW'(N - 1));

    adder_chunk_select #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a_i      (a_q[base +: CHUNK]),
        .b_i      (b_q[base +: CHUNK]),
        .cin_sel_i(carry_q),
        .sum_o    (chunk_sum),
        .cout_o   (chunk_carry)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (istream_val) begin
                    state_d = StCalc;
                    k_d     = '0;
                    a_d     = in0;
                    b_d     = sub ? ~in1 : in1;
                    // Subtraction supplies its own +1, so cin is ignored then.
                    carry_d = sub | cin;
                end
            end
            StCalc: begin
                sum_d[base +: CHUNK] = chunk_sum;
                carry_d              = chunk_carry;
                if (last) begin
                    state_d = StDone;
                    k_d     = '0;
                    ovf_d   = (a_q[NBITS-1] == b_q[NBITS-1]) &&
                              (chunk_sum[CHUNK-1] != a_q[NBITS-1]);
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDone: begin
                if (ostream_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign istream_rdy = (state_q == StIdle);
    assign ostream_val = (state_q == StDone);
    assign sum         = sum_q;
    assign cout        = carry_q;
    assign ovf         = ovf_q;

endmodule
